// File: rtl/riscv_regfile_mp.sv
// -----------------------------------------------------------------------------
// riscv_regfile_mp
//   Multi-ported integer register file for a multi-issue RISC-V core.
//   After reset a CLEAR sequence zeroes registers 1..NREGS-1, one per cycle.
//   The block then enters RUN and accepts writes. Register 0 is hardwired to
//   zero. Reads are combinational. Same-cycle write-to-read forwarding is
//   available as a build option. Same-address write collisions resolve to the
//   youngest (highest-index) port, and each such collision is counted.
//
// Parameters
//   XLEN    register width
//   NREGS   register count (power of two, >= 4)
//   NRD     read ports
//   NWR     write ports (higher index = younger instruction)
//   BYPASS  1: a read sees a same-cycle write to its address
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset (restarts the clear sequence)
//   rd_addr       NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data       NRD packed read data,      port k at [k*XLEN +: XLEN]
//   wr_en         per-port write enable
//   wr_addr       NWR packed write addresses
//   wr_data       NWR packed write data
//   ready         clear sequence finished, writes accepted
//   wr_conflict   pulse: the previous cycle had an accepted write collision
//   conflict_cnt  saturating count of cycles with accepted write collisions
// -----------------------------------------------------------------------------
module riscv_regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 4,
   parameter int NWR    = 2,
   parameter bit BYPASS = 1'b1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [NRD*XLEN-1:0]   rd_data,
   input  logic [NWR-1:0]        wr_en,
   input  logic [NWR*AW-1:0]     wr_addr,
   input  logic [NWR*XLEN-1:0]   wr_data,
   output logic                  ready,
   output logic                  wr_conflict,
   output logic [15:0]           conflict_cnt
);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t          state, state_next;
   logic [AW-1:0]   idx, idx_next;
   logic [XLEN-1:0] regs [NREGS];
   logic            accept;
   logic            collide;

   // Writes are only honoured in RUN and never in a reset cycle.
   assign accept = (state == RUN) && !rst;
   assign ready  = (state == RUN);

   // Any pair of enabled ports aimed at the same nonzero register. A cycle
   // counts once no matter how many ports collide.
   always_comb begin
      collide = 1'b0;
      for (int i = 0; i < NWR; i++) begin
         for (int j = i + 1; j < NWR; j++) begin
            if (wr_en[i] && wr_en[j] &&
                (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]) &&
                (wr_addr[i*AW +: AW] != '0)) begin
               collide = 1'b1;
            end
         end
      end
   end

   // Clear walks idx from 1 to NREGS-1; the last zeroed register hands over
   // to RUN. idx wraps afterwards but is unused outside CLEAR.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      if (state == CLEAR) begin
         idx_next = idx + AW'(1);
         if (idx == AW'(NREGS - 1)) begin
            state_next = RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= CLEAR;
         idx          <= AW'(1);
         wr_conflict  <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         state       <= state_next;
         idx         <= idx_next;
         wr_conflict <= accept && collide;
         if (accept && collide && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
         end
      end
   end

   // NOTE: the array has no reset branch. Zeroing every entry in one cycle
   // would force flops instead of RAM; the CLEAR walk zeroes it instead, and
   // reads are masked to 0 until that finishes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            regs[idx] <= '0;
         end else begin
            // NOTE: several non-blocking writes to one entry in a single pass
            // keep the last one, so the ascending loop gives the youngest
            // port priority on a collision.
            for (int i = 0; i < NWR; i++) begin
               if (wr_en[i] && (wr_addr[i*AW +: AW] != '0)) begin
                  regs[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
               end
            end
         end
      end
   end

   // Reads: 0 during CLEAR and for x0; otherwise the stored value, optionally
   // replaced by the youngest matching write of this cycle.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NRD; k++) begin
         if ((state == RUN) && (rd_addr[k*AW +: AW] != '0)) begin
            rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
            if (BYPASS && !rst) begin
               for (int i = 0; i < NWR; i++) begin
                  if (wr_en[i] && (wr_addr[i*AW +: AW] == rd_addr[k*AW +: AW])) begin
                     rd_data[k*XLEN +: XLEN] = wr_data[i*XLEN +: XLEN];
                  end
               end
            end
         end
      end
   end

endmodule
